// File: rtl/riscv_multicycle_core.sv
// rtl/riscv_multicycle_core.sv - multi-cycle RISC-V subset core on one ready-handshaked memory port
// FETCH/DECODE/EXEC/MEM/WB sequencer; illegal encodings or misaligned branch targets park it in HALT.
module riscv_multicycle_core #(
  parameter int              XLEN     = 64,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            retire,
  output logic [XLEN-1:0] pc_out,
  output logic            halted
);
  localparam int         RIDX    = $clog2(NREGS);
  localparam logic [2:0] F3_LDST = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic            retire_q, retire_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            rf_we;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  function automatic logic reg_oob(input logic [4:0] r);
    return int'({27'b0, r}) >= NREGS;
  endfunction

  logic is_r, is_imm, is_ld, is_st, is_br, legal, bad_reg;
  logic [XLEN-1:0] imm_dec, rs1_val, rs2_val;

  always_comb begin
    is_r    = (opcode == OP_R) &&
              ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b110 || funct3 == 3'b111)) ||
               (funct7 == 7'b0100000 && funct3 == 3'b000));
    is_imm  = (opcode == OP_IMM) && (funct3 == 3'b000);
    is_ld   = (opcode == OP_LD) && (funct3 == F3_LDST);
    is_st   = (opcode == OP_ST) && (funct3 == F3_LDST);
    is_br   = (opcode == OP_BR) &&
              (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b101);
    legal   = is_r || is_imm || is_ld || is_st || is_br;
    // Only the register fields an instruction actually uses are range-checked.
    bad_reg = ((is_r || is_imm || is_ld) && reg_oob(rd)) ||
              reg_oob(rs1) ||
              ((is_r || is_st || is_br) && reg_oob(rs2));
    if (is_st)
      imm_dec = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    else if (is_br)
      imm_dec = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    else
      imm_dec = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1[RIDX-1:0]];
    rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2[RIDX-1:0]];
  end

  logic [XLEN-1:0] alu_res, pc_inc, br_target;
  logic            br_taken;

  always_comb begin
    pc_inc    = pc_q + XLEN'(4);
    br_target = pc_q + imm_q;
    if (is_imm) begin
      alu_res = a_q + imm_q;
    end else begin
      case (funct3)
        3'b111:  alu_res = a_q & b_q;
        3'b110:  alu_res = a_q | b_q;
        default: alu_res = funct7[5] ? (a_q - b_q) : (a_q + b_q);
      endcase
    end
    case (funct3)
      3'b000:  br_taken = (a_q == b_q);
      3'b001:  br_taken = (a_q != b_q);
      3'b100:  br_taken = ($signed(a_q) < $signed(b_q));
      3'b101:  br_taken = ($signed(a_q) >= $signed(b_q));
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    res_d    = res_q;
    retire_d = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_req_q && mem_ready) begin
          ir_d    = mem_rdata[31:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal || bad_reg) begin
          state_d = S_HALT;
        end else begin
          a_d     = rs1_val;
          b_d     = rs2_val;
          imm_d   = imm_dec;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_br) begin
          if (!br_taken) begin
            pc_d     = pc_inc;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end else if (br_target[1:0] != 2'b00) begin
            state_d = S_HALT;
          end else begin
            pc_d     = br_target;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (is_ld || is_st) begin
          res_d   = a_q + imm_q;
          state_d = S_MEM;
        end else begin
          res_d   = alu_res;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_req_q && mem_ready) begin
          if (is_st) begin
            pc_d     = pc_inc;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            res_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        pc_d     = pc_inc;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
      end
      default: state_d = S_HALT;
    endcase

    // Bus outputs are registered from the next state so they hold steady across wait states.
    mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
    mem_we_d    = (state_d == S_MEM) && is_st;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == S_FETCH) begin
      mem_addr_d = pc_d;
    end else if (state_d == S_MEM) begin
      mem_addr_d = res_d;
      if (is_st) mem_wdata_d = b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      res_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      retire_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      res_q       <= res_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      retire_q    <= retire_d;
      if (rf_we && rd != 5'd0) regs_q[rd[RIDX-1:0]] <= res_q;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign retire    = retire_q;
  assign pc_out    = pc_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// tb/tb_riscv_multicycle_core.sv - directed-vector bench for riscv_multicycle_core (XLEN=64, NREGS=16)
// Code lives below 0x80 (zero-wait); data at 0x80..0xFF gets dwait wait states per access.
module tb_riscv_multicycle_core;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [31:0] ILL   = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  logic [31:0] imem [0:31];
  logic [63:0] dmem [0:15];
  int          dwait = 0;
  int          wcnt  = 0;
  logic        block = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] p2_addr [3] = '{64'd128, 64'd128, 64'd136};
  logic        p2_we   [3] = '{1'b1, 1'b0, 1'b1};
  int          p2_lat  [4] = '{0, 6, 7, 6};
  logic [63:0] p3_pc   [15] = '{64'h04, 64'h08, 64'h0C, 64'h10, 64'h14, 64'h18, 64'h1C, 64'h20,
                                64'h28, 64'h2C, 64'h34, 64'h38, 64'h34, 64'h38, 64'h34};
  int          p3_lat  [15] = '{0, 4, 4, 4, 4, 4, 4, 4, 3, 3, 3, 4, 3, 4, 3};

  riscv_multicycle_core #(.XLEN(64), .NREGS(16), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .pc_out(pc_out), .halted(halted)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (mem_addr < 64'd128) mem_rdata = {32'h0, imem[mem_addr[6:2]]};
    else                    mem_rdata = dmem[mem_addr[6:3]];
    mem_ready = !block && ((mem_addr < 64'd128) || (wcnt >= dwait));
  end

  always @(posedge clk) begin
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
    if (reset) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 64'hA5A5_A5A5_A5A5_A5A5;
    end else if (mem_req && mem_we && mem_ready && mem_addr >= 64'd128) begin
      dmem[mem_addr[6:3]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] e_i(input logic [6:0] op, input logic [2:0] f3,
                                      input int rd, input int rs1, input int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] e_sd(input int rs2, input int rs1, input int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b011, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] e_b(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = ILL;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_retire(input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!retire && cyc < max);
    check("retire_seen", {63'b0, retire}, 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, nret, nwait, idx, last;
    reset = 1'b1;

    // Program 1: ALU ops, zero-wait memory
    clear_imem();
    imem[0] = e_i(OP_IMM, 3'b000, 1, 0, 5);
    imem[1] = e_i(OP_IMM, 3'b000, 2, 0, -3);
    imem[2] = e_r(7'h00, 3'b000, 3, 1, 2);
    imem[3] = e_r(7'h20, 3'b000, 4, 1, 2);
    imem[4] = e_r(7'h00, 3'b111, 6, 1, 2);
    imem[5] = e_r(7'h00, 3'b110, 7, 1, 2);
    imem[6] = e_sd(3, 0, 128);
    imem[7] = e_sd(4, 0, 136);
    imem[8] = e_sd(6, 0, 144);
    imem[9] = e_sd(7, 0, 152);
    repeat (2) @(negedge clk);
    check("rst_mem_req", {63'b0, mem_req}, 64'd0);
    check("rst_mem_we", {63'b0, mem_we}, 64'd0);
    check("rst_retire", {63'b0, retire}, 64'd0);
    check("rst_halted", {63'b0, halted}, 64'd0);
    check("rst_pc", pc_out, 64'h0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    check("c1_mem_req", {63'b0, mem_req}, 64'd1);
    check("c1_mem_addr", mem_addr, 64'h0);
    check("c1_mem_we", {63'b0, mem_we}, 64'd0);
    check("c1_retire", {63'b0, retire}, 64'd0);
    wait_retire(20, cyc);
    for (int i = 1; i < 10; i++) begin
      wait_retire(20, cyc);
      check($sformatf("p1_lat%0d", i), 64'(cyc), 64'd4);
    end
    repeat (6) @(negedge clk);
    check("p1_halted", {63'b0, halted}, 64'd1);
    check("p1_halt_req", {63'b0, mem_req}, 64'd0);
    check("p1_halt_pc", pc_out, 64'h28);
    check("p1_x3_add", dmem[0], 64'd2);
    check("p1_x4_sub", dmem[1], 64'd8);
    check("p1_x6_and", dmem[2], 64'd5);
    check("p1_x7_or", dmem[3], 64'hFFFF_FFFF_FFFF_FFFD);

    // Program 2: store/load with two wait states per data access
    clear_imem();
    imem[0] = e_i(OP_IMM, 3'b000, 4, 0, 8);
    imem[1] = e_sd(4, 0, 128);
    imem[2] = e_i(OP_LD, 3'b011, 5, 0, 128);
    imem[3] = e_sd(5, 0, 136);
    dwait = 2;
    do_reset();
    nret = 0; nwait = 0; idx = 0; last = 0;
    for (int c = 1; c <= 80 && !halted; c++) begin
      @(negedge clk);
      if (mem_req && mem_addr >= 64'd128 && idx < 3) begin
        check("p2_addr", mem_addr, p2_addr[idx]);
        check("p2_we", {63'b0, mem_we}, {63'b0, p2_we[idx]});
        if (p2_we[idx]) check("p2_wdata", mem_wdata, 64'd8);
        if (!mem_ready) nwait++;
        else            idx++;
      end
      if (retire) begin
        if (nret > 0 && nret < 4) check($sformatf("p2_lat%0d", nret), 64'(c - last), 64'(p2_lat[nret]));
        last = c;
        nret++;
      end
    end
    check("p2_nret", 64'(nret), 64'd4);
    check("p2_nwait", 64'(nwait), 64'd6);
    check("p2_ld_x5", dmem[1], 64'd8);
    dwait = 0;

    // Program 3: branches, x0 discard, backward loop
    clear_imem();
    imem[0]  = e_i(OP_IMM, 3'b000, 1, 0, -1);
    imem[1]  = e_i(OP_IMM, 3'b000, 2, 0, 1);
    imem[2]  = e_i(OP_IMM, 3'b000, 0, 0, 7);
    imem[3]  = e_sd(0, 0, 128);
    imem[4]  = e_i(OP_IMM, 3'b000, 3, 0, 0);
    imem[5]  = e_i(OP_IMM, 3'b000, 3, 3, 1);
    imem[6]  = e_i(OP_IMM, 3'b000, 3, 3, 1);
    imem[7]  = e_i(OP_IMM, 3'b000, 3, 3, 1);
    imem[8]  = e_b(3'b100, 1, 2, 8);
    imem[9]  = e_i(OP_IMM, 3'b000, 3, 3, 100);
    imem[10] = e_b(3'b101, 1, 2, 8);
    imem[11] = e_b(3'b001, 1, 2, 8);
    imem[12] = e_i(OP_IMM, 3'b000, 3, 3, 100);
    imem[13] = e_sd(3, 0, 136);
    imem[14] = e_b(3'b000, 0, 0, -4);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      wait_retire(20, cyc);
      check($sformatf("p3_pc%0d", i), pc_out, p3_pc[i]);
      if (i > 0) check($sformatf("p3_lat%0d", i), 64'(cyc), 64'(p3_lat[i]));
    end
    check("p3_x0_store", dmem[0], 64'd0);
    check("p3_x3_store", dmem[1], 64'd3);

    // Program 4: illegal opcode 0x7F
    clear_imem();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    check("p4_decode_halted", {63'b0, halted}, 64'd0);
    @(negedge clk);
    check("p4_halted", {63'b0, halted}, 64'd1);
    nret = 0;
    repeat (5) begin
      @(negedge clk);
      nret += int'(retire);
    end
    check("p4_req", {63'b0, mem_req}, 64'd0);
    check("p4_pc", pc_out, 64'h0);
    check("p4_nret", 64'(nret), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("p4_reset_clears", {63'b0, halted}, 64'd0);

    // Program 5a: rd=x20 beyond NREGS=16
    clear_imem();
    imem[0] = e_i(OP_IMM, 3'b000, 20, 0, 1);
    do_reset();
    repeat (3) @(negedge clk);
    check("p5_rd20_halted", {63'b0, halted}, 64'd1);
    check("p5_rd20_req", {63'b0, mem_req}, 64'd0);

    // Program 5b: taken branch to a misaligned target
    clear_imem();
    imem[0] = e_i(OP_IMM, 3'b000, 1, 0, 1);
    imem[1] = e_b(3'b000, 0, 0, 6);
    do_reset();
    nret = 0;
    repeat (25) begin
      @(negedge clk);
      nret += int'(retire);
    end
    check("p5_mis_nret", 64'(nret), 64'd1);
    check("p5_mis_halted", {63'b0, halted}, 64'd1);
    check("p5_mis_pc", pc_out, 64'h4);

    // Program 6: reset while a fetch is stalled
    clear_imem();
    imem[0] = e_i(OP_IMM, 3'b000, 3, 0, 9);
    imem[1] = e_sd(3, 0, 128);
    imem[2] = e_i(OP_IMM, 3'b000, 3, 3, 1);
    do_reset();
    wait_retire(20, cyc);
    wait_retire(20, cyc);
    check("p6_pre_store", dmem[0], 64'd9);
    block = 1'b1;
    repeat (3) @(negedge clk);
    check("p6_stall_req", {63'b0, mem_req}, 64'd1);
    check("p6_stall_addr", mem_addr, 64'h8);
    reset = 1'b1;
    @(negedge clk);
    check("p6_rst_req", {63'b0, mem_req}, 64'd0);
    check("p6_rst_pc", pc_out, 64'h0);
    clear_imem();
    imem[0] = e_sd(3, 0, 128);
    reset = 1'b0;
    block = 1'b0;
    wait_retire(20, cyc);
    check("p6_regs_cleared", dmem[0], 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
